lcd_write_arbiter: RTL and testbench

Shares the single character-LCD write bus between NREQ display requesters (clock display, clock-set editor, alarm-set editor). It arbitrates round-robin and latches the winner's RS/data byte. It then runs the full HD44780-style write cycle (setup, E pulse, hold, execution wait) and acks the requester. It sits between the mode-specific display formatters and the top-level LCD_E/LCD_RS/LCD_RW/LCD_DATA pins.

---
 rtl/lcd_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/lcd_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_lcd_write_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared HD44780 command constants, RS encodings and write-FSM states
// Imported by lcd_write_arbiter and rr_arbiter.
package lcd_pkg;

  localparam logic [7:0] LCD_CLEAR        = 8'h01;
  localparam logic [7:0] LCD_HOME         = 8'h02;
  localparam logic [7:0] LCD_HOME_ALT     = 8'h03;
  localparam logic [7:0] LCD_ENTRY        = 8'h06;
  localparam logic [7:0] LCD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] LCD_FUNCTION_SET = 8'h38;
  localparam logic [7:0] LCD_SET_DDRAM    = 8'h80;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  typedef logic [2:0] lcd_state_t;
  localparam lcd_state_t ST_IDLE  = 3'd0;
  localparam lcd_state_t ST_SETUP = 3'd1;
  localparam lcd_state_t ST_PULSE = 3'd2;
  localparam lcd_state_t ST_HOLD  = 3'd3;
  localparam lcd_state_t ST_EXEC  = 3'd4;
  localparam lcd_state_t ST_DONE  = 3'd5;

  // Clear and return-home need the long execution wait on the controller.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == RS_CMD) &&
           ((data == LCD_CLEAR) || (data == LCD_HOME) || (data == LCD_HOME_ALT));
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or above pointer
// Pointer must be below NREQ; outputs are zero when no request is set.
module rr_arbiter
  import lcd_pkg::*;
#(
  parameter int NREQ = 3,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   pointer,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   index
);

  logic [IW:0] cand;
  logic        found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, pointer} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(NREQ)) cand = cand - (IW + 1)'(NREQ);
      if (!found && req[cand[IW-1:0]]) begin
        found                = 1'b1;
        grant[cand[IW-1:0]]  = 1'b1;
        index                = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// rtl/lcd_write_arbiter.sv - round-robin sharing of the LCD write bus with full E-strobe write cycle
// Optional grant lock for multi-byte sequences: LCD_ARB_LOCK_EN.
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int T_SETUP     = 1,
  parameter int T_PULSE     = 1,
  parameter int T_HOLD      = 1,
  parameter int T_EXEC      = 40,
  parameter int T_EXEC_LONG = 1640
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rs,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   lock,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic              LCD_E,
  output logic              LCD_RS,
  output logic              LCD_RW,
  output logic [7:0]        LCD_DATA
);

  localparam int IW   = $clog2(NREQ);
  localparam int TMAX = max2(max2(max2(T_SETUP, T_PULSE), max2(T_HOLD, T_EXEC)), T_EXEC_LONG);
  localparam int CW   = $clog2(TMAX + 1);

  lcd_state_t      state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   ptr;
  logic [NREQ-1:0] granted;
  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_index;
  logic            sel_rs;
  logic [7:0]      sel_data;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req     (req),
    .pointer (ptr),
    .grant   (arb_grant),
    .index   (arb_index)
  );

  always_comb begin
    sel_rs   = 1'b0;
    sel_data = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_index == IW'(i)) begin
        sel_rs   = req_rs[i];
        sel_data = req_data[8*i +: 8];
      end
    end
  end

  assign busy   = (state != ST_IDLE);
  assign LCD_RW = 1'b0;

`ifndef LCD_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  // E and ack are registered off the state, so both lag the state by one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ptr      <= '0;
      granted  <= '0;
      ack      <= '0;
      LCD_E    <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DATA <= 8'h00;
    end else begin
      LCD_E <= (state == ST_PULSE);
      ack   <= (state == ST_DONE) ? granted : '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            granted  <= arb_grant;
            LCD_RS   <= sel_rs;
            LCD_DATA <= sel_data;
            ptr      <= (arb_index == IW'(NREQ - 1)) ? '0 : arb_index + 1'b1;
            cnt      <= CW'(T_SETUP - 1);
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            cnt   <= CW'(T_PULSE - 1);
            state <= ST_PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            cnt   <= CW'(T_HOLD - 1);
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            cnt   <= is_long_cmd(LCD_RS, LCD_DATA) ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
            state <= ST_EXEC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
`ifdef LCD_ARB_LOCK_EN
          // Holding the pointer on the owner lets it win the next IDLE again.
          if (|(lock & granted)) begin
            for (int i = 0; i < NREQ; i++) begin
              if (granted[i]) ptr <= IW'(i);
            end
          end
`endif
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb/tb_lcd_write_arbiter.sv - scoreboard bench for lcd_write_arbiter with a transaction-level model
// Lock expectations follow LCD_ARB_LOCK_EN when the bench is compiled with it.
module tb_lcd_write_arbiter;

  localparam int NREQ = 3;
  localparam int TS   = 1;
  localparam int TP   = 1;
  localparam int TH   = 1;
  localparam int TE   = 40;
  localparam int TEL  = 1640;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   req_rs = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   lock = '0;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic              LCD_E;
  logic              LCD_RS;
  logic              LCD_RW;
  logic [7:0]        LCD_DATA;

  lcd_write_arbiter #(
    .NREQ(NREQ), .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_EXEC(TE), .T_EXEC_LONG(TEL)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_rs(req_rs), .req_data(req_data),
    .lock(lock), .ack(ack), .busy(busy), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic       rs;
    logic [7:0] data;
    int         lat;
  } exp_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
  } item_t;

  exp_t  exp_q[$];
  item_t drv_q[NREQ][$];
  int    mptr = 0;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Transaction-level model: serve non-empty queues round-robin, one byte per grant.
  task automatic plan(input logic [NREQ-1:0] lk, output int budget);
    item_t m[NREQ][$];
    int    g;
    exp_t  e;
    for (int i = 0; i < NREQ; i++) m[i] = drv_q[i];
    budget = 50;
    forever begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && m[(mptr + k) % NREQ].size() > 0) g = (mptr + k) % NREQ;
      end
      if (g < 0) break;
      e.idx  = g;
      e.rs   = m[g][0].rs;
      e.data = m[g][0].data;
      e.lat  = TS + TP + TH + 1 +
               (((e.rs == 1'b0) && (e.data >= 8'h01) && (e.data <= 8'h03)) ? TEL : TE);
      exp_q.push_back(e);
      budget += e.lat + 2;
      void'(m[g].pop_front());
`ifdef LCD_ARB_LOCK_EN
      mptr = lk[g] ? g : (g + 1) % NREQ;
`else
      mptr = (g + 1) % NREQ;
`endif
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (drv_q[i].size() > 0);
      if (drv_q[i].size() > 0) begin
        req_rs[i]         = drv_q[i][0].rs;
        req_data[8*i +: 8] = drv_q[i][0].data;
      end else begin
        req_rs[i]         = $urandom_range(0, 1);
        req_data[8*i +: 8] = 8'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic push_item(input int i, input logic rs, input logic [7:0] data);
    item_t it;
    it.rs   = rs;
    it.data = data;
    drv_q[i].push_back(it);
  endtask

  function automatic bit drv_empty();
    for (int i = 0; i < NREQ; i++) if (drv_q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_phase(input logic [NREQ-1:0] lk);
    int  budget;
    bit  done;
    plan(lk, budget);
    lock = lk;
    apply();
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
      end
      apply();
      if (drv_empty() && exp_q.size() == 0 && !busy) done = 1'b1;
    end
    chk("phase_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: binds each grant to the head of the scoreboard and checks it at ack.
  exp_t cur;
  bit   active = 1'b0;
  bit   stable;
  int   gcyc, erise, ecnt;

  always @(negedge clk) begin
    if (!resetn) begin
      active = 1'b0;
    end else begin
      if (ack != '0) begin
        if (!active) begin
          chk("ack_without_grant", int'(ack), 0);
        end else begin
          chk("ack_onehot", int'(ack), 1 << cur.idx);
          chk("ack_latency", cyc - gcyc, cur.lat);
          chk("busy_low_at_ack", int'(busy), 0);
          chk("e_rise_offset", erise, TS + 1);
          chk("e_width", ecnt, TP);
          chk("rs_data_stable", int'(stable), 1);
          chk("rw_low", int'(LCD_RW), 0);
          active = 1'b0;
          void'(exp_q.pop_front());
        end
      end
      if (busy && !active) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", int'(busy), 0);
        end else begin
          cur    = exp_q[0];
          active = 1'b1;
          gcyc   = cyc;
          erise  = -1;
          ecnt   = 0;
          stable = 1'b1;
          chk("grant_rs", int'(LCD_RS), int'(cur.rs));
          chk("grant_data", int'(LCD_DATA), int'(cur.data));
        end
      end
      if (active) begin
        if (LCD_RS !== cur.rs || LCD_DATA !== cur.data) stable = 1'b0;
        if (LCD_E === 1'b1) begin
          if (erise < 0) erise = cyc - gcyc;
          ecnt++;
        end
      end
    end
  end

  initial begin
    int w;
    int acks;
    logic [7:0] d;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({ack, busy, LCD_E, LCD_RS, LCD_RW, LCD_DATA}), 0);
    resetn = 1'b1;

    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      chk("idle_outputs", int'({ack, busy, LCD_E, LCD_RS, LCD_RW, LCD_DATA}), 0);
    end

    push_item(1, 1'b1, 8'h31);
    run_phase('0);

    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) push_item(i, 1'b1, 8'(8'h41 + 3*r + i));
    run_phase('0);

    push_item(0, 1'b0, 8'h01);
    push_item(0, 1'b1, 8'h01);
    run_phase('0);

    // Abort in the middle of the E pulse.
    push_item(0, 1'b1, 8'h55);
    plan('0, w);
    apply();
    w = 0;
    while (!LCD_E && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("e_seen_before_reset", int'(LCD_E), 1);
    #2 resetn = 1'b0;
    #1;
    chk("e_async_low", int'(LCD_E), 0);
    chk("busy_async_low", int'(busy), 0);
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) drv_q[i].delete();
    req  = '0;
    mptr = 0;
    acks = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ack != '0) acks++;
      if (n == 3) resetn = 1'b1;
    end
    chk("no_ack_after_abort", acks, 0);
    push_item(0, 1'b1, 8'h55);
    run_phase('0);

    push_item(0, 1'b1, 8'h80);
    push_item(1, 1'b1, 8'h81);
    for (int r = 0; r < 3; r++) push_item(2, 1'b1, 8'(8'hA0 + r));
    push_item(0, 1'b1, 8'h82);
    run_phase(3'b100);

    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < NREQ; i++) begin
        int cnt_items = $urandom_range(0, 4);
        for (int k = 0; k < cnt_items; k++) begin
          if ($urandom_range(0, 15) == 0) d = 8'($urandom_range(1, 3));
          else d = 8'($urandom_range(0, 255));
          push_item(i, 1'($urandom_range(0, 1)), d);
        end
      end
      run_phase(NREQ'($urandom_range(0, (1 << NREQ) - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
